// File: rtl/upsamp.sv
// 2x nearest-neighbour upsampler: reads an N x N map and writes each pixel
// into a 2x2 block of a 2N x 2N map.
module upsamp #(
  parameter int SIZE             = 16,
  parameter int SIZE_address_pix = 13
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               upsamp_en,
  input  logic        [SIZE_address_pix-1:0] memstartp,
  input  logic        [SIZE_address_pix-1:0] memstartzap,
  input  logic        [4:0]                  matrix,
  output logic        [SIZE_address_pix-1:0] read_addressp,
  output logic                               re,
  input  logic signed [SIZE-1:0]             qp,
  output logic        [SIZE_address_pix-1:0] write_addressp,
  output logic                               we,
  output logic signed [SIZE-1:0]             dp,
  output logic                               STOP
);

  localparam int AW = SIZE_address_pix;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, CAPTURE, WR1, WR2, WR3, NEXT, DONE
  } state_t;

  state_t        state;
  logic [9:0]    k;
  logic [4:0]    row;
  logic [4:0]    col;
  logic [AW-1:0] offset;
  logic [AW-1:0] side_m;
  logic [AW-1:0] base_b;
  logic          last_pix;

  // offset tracks 2r*M + 2c incrementally, so no divider or multiplier is needed
  assign side_m   = AW'({matrix, 1'b0});
  assign base_b   = memstartzap + offset;
  assign last_pix = (row == matrix - 5'd1) && (col == matrix - 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      read_addressp  <= '0;
      write_addressp <= '0;
      dp             <= '0;
      re             <= 1'b0;
      we             <= 1'b0;
      STOP           <= 1'b0;
      k              <= '0;
      row            <= '0;
      col            <= '0;
      offset         <= '0;
      state          <= IDLE;
    end else if (!upsamp_en) begin
      // dropping the enable abandons the run; addresses and data just hold
      re     <= 1'b0;
      we     <= 1'b0;
      STOP   <= 1'b0;
      k      <= '0;
      row    <= '0;
      col    <= '0;
      offset <= '0;
      state  <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (matrix == 5'd0) begin
            STOP  <= 1'b1;
            state <= DONE;
          end else begin
            read_addressp <= memstartp;
            re            <= 1'b1;
            k             <= '0;
            row           <= '0;
            col           <= '0;
            offset        <= '0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: state <= CAPTURE;
        CAPTURE: begin
          dp             <= qp;
          write_addressp <= base_b;
          we             <= 1'b1;
          state          <= WR1;
        end
        WR1: begin
          write_addressp <= base_b + AW'(1);
          state          <= WR2;
        end
        WR2: begin
          write_addressp <= base_b + side_m;
          state          <= WR3;
        end
        WR3: begin
          write_addressp <= base_b + side_m + AW'(1);
          state          <= NEXT;
        end
        NEXT: begin
          we <= 1'b0;
          if (last_pix) begin
            re    <= 1'b0;
            STOP  <= 1'b1;
            state <= DONE;
          end else begin
            k             <= k + 10'd1;
            read_addressp <= memstartp + AW'(k + 10'd1);
            if (col == matrix - 5'd1) begin
              col    <= '0;
              row    <= row + 5'd1;
              offset <= offset + side_m + AW'(2);
            end else begin
              col    <= col + 5'd1;
              offset <= offset + AW'(2);
            end
            state <= RD_WAIT;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsamp.sv
// Directed bench for upsamp with a one-register-read pixel RAM model.
module tb_upsamp;

  localparam int SIZE = 8;
  localparam int AW   = 8;

  logic                   clk;
  logic                   rst;
  logic                   upsamp_en;
  logic        [AW-1:0]   memstartp;
  logic        [AW-1:0]   memstartzap;
  logic        [4:0]      matrix;
  logic        [AW-1:0]   read_addressp;
  logic                   re;
  logic signed [SIZE-1:0] qp;
  logic        [AW-1:0]   write_addressp;
  logic                   we;
  logic signed [SIZE-1:0] dp;
  logic                   STOP;

  logic signed [SIZE-1:0] mem [256];
  logic                   ld_en;
  logic        [AW-1:0]   ld_addr;
  logic signed [SIZE-1:0] ld_data;

  int vectors;
  int miscompares;

  upsamp #(.SIZE(SIZE), .SIZE_address_pix(AW)) dut (
    .clk(clk), .rst(rst), .upsamp_en(upsamp_en),
    .memstartp(memstartp), .memstartzap(memstartzap), .matrix(matrix),
    .read_addressp(read_addressp), .re(re), .qp(qp),
    .write_addressp(write_addressp), .we(we), .dp(dp), .STOP(STOP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address registered at edge 0 is read here at edge 1, so qp is ready for edge 2
  always @(posedge clk) begin
    qp <= mem[read_addressp];
    if (we) mem[write_addressp] <= dp;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic poke(input logic [AW-1:0] a, input logic signed [SIZE-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({read_addressp, write_addressp, dp, re, we, STOP} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ra=%0d wa=%0d dp=%0d re=%b we=%b stop=%b want all 0",
               read_addressp, write_addressp, dp, re, we, STOP);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic signed [SIZE-1:0] exp16 [16] = '{5, 5, -3, -3, 5, 5, -3, -3, 7, 7, 0, 0, 7, 7, 0, 0};
    logic [AW-1:0] exp_wa [4] = '{8'd100, 8'd101, 8'd104, 8'd105};
    logic [AW-1:0] wa [4];
    int stop_e, wecnt, grp, run, maxrun, re_gaps;
    logic prev_we;
    poke(0, 5); poke(1, -3); poke(2, 7); poke(3, 0);
    for (int i = 100; i < 116; i++) poke(AW'(i), 8'sh55);
    memstartp = 0; memstartzap = 100; matrix = 2;
    upsamp_en = 1'b1;
    stop_e = -1; wecnt = 0; grp = 0; run = 0; maxrun = 0; re_gaps = 0; prev_we = 1'b0;
    for (int e = 0; e < 40 && stop_e < 0; e++) begin
      @(posedge clk); #1;
      if (we) begin
        if (wecnt < 4) wa[wecnt] = write_addressp;
        wecnt++;
        if (!prev_we) begin grp++; run = 0; end
        run++;
        if (run > maxrun) maxrun = run;
      end
      prev_we = we;
      if (e < 24 && !re) re_gaps++;
      if (STOP) stop_e = e;
    end
    vectors++;
    if (stop_e !== 24) begin miscompares++; $display("FAIL basic_stop_edge: got %0d want 24", stop_e); end
    vectors++;
    if (grp !== 4 || wecnt !== 16 || maxrun !== 4) begin
      miscompares++;
      $display("FAIL basic_we_groups: got groups=%0d cycles=%0d maxrun=%0d want 4/16/4", grp, wecnt, maxrun);
    end
    vectors++;
    if (re_gaps !== 0 || re !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_re_span: got gaps=%0d re_after=%b want 0/0", re_gaps, re);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wa[i] !== exp_wa[i]) begin
        miscompares++;
        $display("FAIL basic_waddr[%0d]: got %0d want %0d", i, wa[i], exp_wa[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (mem[100 + i] !== exp16[i]) begin
        miscompares++;
        $display("FAIL basic_out[%0d]: got %0d want %0d", 100 + i, mem[100 + i], exp16[i]);
      end
    end
    upsamp_en = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    logic saw;
    matrix = 0; memstartp = 0; memstartzap = 100;
    upsamp_en = 1'b1;
    tick();
    vectors++;
    if (STOP !== 1'b1) begin miscompares++; $display("FAIL zero_stop: got %b want 1", STOP); end
    saw = re | we;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw = saw | re | we;
    end
    vectors++;
    if (saw !== 1'b0) begin miscompares++; $display("FAIL zero_no_access: got re/we seen=%b want 0", saw); end
    upsamp_en = 1'b0;
    tick();
    vectors++;
    if (STOP !== 1'b0) begin miscompares++; $display("FAIL zero_stop_clear: got %b want 0", STOP); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_wa [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
    logic [AW-1:0] wa [4];
    logic signed [SIZE-1:0] wd [4];
    int stop_e, wecnt;
    poke(10, -1);
    for (int i = 0; i < 2; i++) begin poke(AW'(i), 0); poke(AW'(254 + i), 0); end
    memstartp = 10; memstartzap = 254; matrix = 1;
    upsamp_en = 1'b1;
    stop_e = -1; wecnt = 0;
    for (int e = 0; e < 20 && stop_e < 0; e++) begin
      @(posedge clk); #1;
      if (we) begin
        if (wecnt < 4) begin wa[wecnt] = write_addressp; wd[wecnt] = dp; end
        wecnt++;
      end
      if (STOP) stop_e = e;
    end
    vectors++;
    if (stop_e !== 6 || wecnt !== 4) begin
      miscompares++;
      $display("FAIL wrap_timing: got stop=%0d we_cycles=%0d want 6/4", stop_e, wecnt);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wa[i] !== exp_wa[i] || wd[i] !== -8'sd1 || mem[exp_wa[i]] !== -8'sd1) begin
        miscompares++;
        $display("FAIL wrap_write[%0d]: got addr=%0d dp=%0d mem=%0d want addr=%0d data=-1",
                 i, wa[i], wd[i], mem[exp_wa[i]], exp_wa[i]);
      end
    end
    upsamp_en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int stop_e, exp_v;
    for (int i = 0; i < 9; i++) poke(AW'(20 + i), SIZE'(i + 1));
    for (int i = 40; i < 76; i++) poke(AW'(i), 0);
    memstartp = 20; memstartzap = 40; matrix = 3;
    upsamp_en = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    vectors++;
    if (we !== 1'b1 || write_addressp !== 8'd55) begin
      miscompares++;
      $display("FAIL abort_pre: got we=%b wa=%0d want 1/55", we, write_addressp);
    end
    upsamp_en = 1'b0;
    tick();
    vectors++;
    if (we !== 1'b0 || re !== 1'b0 || STOP !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ctrl: got we=%b re=%b stop=%b want 0/0/0", we, re, STOP);
    end
    vectors++;
    if (write_addressp !== 8'd55 || dp !== 8'sd5 || read_addressp !== 8'd24) begin
      miscompares++;
      $display("FAIL abort_hold: got wa=%0d dp=%0d ra=%0d want 55/5/24", write_addressp, dp, read_addressp);
    end
    upsamp_en = 1'b1;
    tick();
    vectors++;
    if (read_addressp !== 8'd20 || re !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart: got ra=%0d re=%b want 20/1", read_addressp, re);
    end
    stop_e = -1;
    for (int e = 1; e < 80 && stop_e < 0; e++) begin
      @(posedge clk); #1;
      if (STOP) stop_e = e;
    end
    vectors++;
    if (stop_e !== 54) begin miscompares++; $display("FAIL abort_rerun_stop: got %0d want 54", stop_e); end
    for (int rr = 0; rr < 6; rr++) begin
      for (int cc = 0; cc < 6; cc++) begin
        exp_v = (rr / 2) * 3 + (cc / 2) + 1;
        vectors++;
        if (mem[40 + rr * 6 + cc] !== SIZE'(exp_v)) begin
          miscompares++;
          $display("FAIL abort_out[%0d]: got %0d want %0d", 40 + rr * 6 + cc, mem[40 + rr * 6 + cc], exp_v);
        end
      end
    end
    upsamp_en = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    logic signed [SIZE-1:0] exp16 [16] = '{11, 11, -12, -12, 11, 11, -12, -12, 13, 13, -14, -14, 13, 13, -14, -14};
    int stop_e;
    poke(120, 11); poke(121, -12); poke(122, 13); poke(123, -14);
    for (int i = 130; i < 146; i++) poke(AW'(i), 8'sh55);
    memstartp = 120; memstartzap = 130; matrix = 2;
    upsamp_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    vectors++;
    if ({read_addressp, write_addressp, dp, re, we, STOP} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got ra=%0d wa=%0d dp=%0d re=%b we=%b stop=%b want all 0",
               read_addressp, write_addressp, dp, re, we, STOP);
    end
    rst = 1'b0;
    stop_e = -1;
    for (int e = 0; e < 40 && stop_e < 0; e++) begin
      @(posedge clk); #1;
      if (STOP) stop_e = e;
    end
    vectors++;
    if (stop_e !== 24) begin miscompares++; $display("FAIL rst_mid_stop: got %0d want 24", stop_e); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (mem[130 + i] !== exp16[i]) begin
        miscompares++;
        $display("FAIL rst_mid_out[%0d]: got %0d want %0d", 130 + i, mem[130 + i], exp16[i]);
      end
    end
    upsamp_en = 1'b0;
    tick();
  endtask

  task automatic test_handshake();
    int stop_e, low_cnt, we_cnt;
    poke(200, 33);
    memstartp = 200; memstartzap = 210; matrix = 1;
    upsamp_en = 1'b1;
    stop_e = -1;
    for (int e = 0; e < 20 && stop_e < 0; e++) begin
      @(posedge clk); #1;
      if (STOP) stop_e = e;
    end
    vectors++;
    if (stop_e !== 6) begin miscompares++; $display("FAIL hs_stop_edge: got %0d want 6", stop_e); end
    low_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (STOP !== 1'b1) low_cnt++;
      if (we !== 1'b0) we_cnt++;
    end
    vectors++;
    if (low_cnt !== 0 || we_cnt !== 0) begin
      miscompares++;
      $display("FAIL hs_hold: got stop_low=%0d extra_we=%0d want 0/0", low_cnt, we_cnt);
    end
    vectors++;
    if (mem[210] !== 8'sd33 || mem[213] !== 8'sd33) begin
      miscompares++;
      $display("FAIL hs_data: got %0d/%0d want 33/33", mem[210], mem[213]);
    end
    upsamp_en = 1'b0;
    tick();
    vectors++;
    if (STOP !== 1'b0 || re !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_release: got stop=%b re=%b want 0/0", STOP, re);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; upsamp_en = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    memstartp = '0; memstartzap = '0; matrix = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_abort();
    test_rst_mid();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
